// File: rtl/pad_filter_pkg.sv
// Shared types and constants for the pad input filter.
// The optional edge counter is enabled by defining PAD_INPUT_FILTER_EDGE_CNT_EN.
package pad_filter_pkg;

    // Filter FSM: holding a settled level, or counting a candidate new level.
    typedef enum logic {
        STABLE  = 1'b0,
        QUALIFY = 1'b1
    } pad_filt_state_e;

    // Width of the optional edge counter.
    localparam int EDGE_CNT_W = 16;

endpackage

// File: rtl/pad_sync.sv
// Multi-flop synchronizer bringing the asynchronous pad input into clk_i.
// The chain resets to RESET_VAL so a pull-up pad does not show a false edge after reset.
module pad_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    // Shift the pad sample through the chain every cycle, independent of any enable.
    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking assignments let every stage sample its predecessor's old value,
        // which is what makes this a shift chain rather than a single flop.
        if (rst_i) begin
            sync_q <= {STAGES{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pad_input_filter.sv
// Pad receive conditioning: synchronizer, programmable glitch filter, edge pulses.
// A new level is accepted after filt_len_i+1 consecutive equal synchronized samples.
// Defining PAD_INPUT_FILTER_EDGE_CNT_EN adds a 16-bit wrapping edge counter with clear.
module pad_input_filter
    import pad_filter_pkg::*;
#(
    parameter int   SYNC_STAGES = 2,
    parameter int   FILT_W      = 8,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic              pad_i,
    input  logic [FILT_W-1:0] filt_len_i,
`ifdef PAD_INPUT_FILTER_EDGE_CNT_EN
    input  logic                  cnt_clr_i,
    output logic [EDGE_CNT_W-1:0] edge_cnt_o,
`endif
    output logic              level_o,
    output logic              rise_o,
    output logic              fall_o,
    output logic              glitch_o
);

    logic              s;
    pad_filt_state_e   state;
    logic [FILT_W-1:0] cnt;
    logic [FILT_W-1:0] len_q;

    pad_sync #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (RESET_VAL)
    ) u_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (pad_i),
        .q_o   (s)
    );

    // Filter FSM: qualify a differing synchronized sample for len_q+1 cycles before accepting it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= STABLE;
            cnt      <= '0;
            len_q    <= '0;
            level_o  <= RESET_VAL;
            rise_o   <= 1'b0;
            fall_o   <= 1'b0;
            glitch_o <= 1'b0;
        end else begin
            // Pulses default low so each one lasts exactly one cycle.
            rise_o   <= 1'b0;
            fall_o   <= 1'b0;
            glitch_o <= 1'b0;
            if (!en_i) begin
                state <= STABLE;
                cnt   <= '0;
            end else begin
                case (state)
                    STABLE: begin
                        if (s != level_o) begin
                            if (filt_len_i == '0) begin
                                level_o <= s;
                                rise_o  <= s;
                                fall_o  <= ~s;
                            end else begin
                                // Length is captured here so later changes do not disturb this run.
                                cnt   <= FILT_W'(1);
                                len_q <= filt_len_i;
                                state <= QUALIFY;
                            end
                        end
                    end
                    QUALIFY: begin
                        if (s == level_o) begin
                            glitch_o <= 1'b1;
                            cnt      <= '0;
                            state    <= STABLE;
                        end else if (cnt == len_q) begin
                            // Accept on equality, so cnt never has to reach 2^FILT_W.
                            level_o <= s;
                            rise_o  <= s;
                            fall_o  <= ~s;
                            cnt     <= '0;
                            state   <= STABLE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: begin
                        state <= STABLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

`ifdef PAD_INPUT_FILTER_EDGE_CNT_EN
    // Count accepted edges; a clear takes priority over a same-cycle increment.
    always_ff @(posedge clk_i) begin
        if (rst_i || cnt_clr_i) begin
            edge_cnt_o <= '0;
        end else if (rise_o || fall_o) begin
            edge_cnt_o <= edge_cnt_o + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pad_input_filter.sv
// Self-checking bench for pad_input_filter: directed scenarios followed by random
// pad/enable/length/reset traffic, all compared every cycle against a run-length model.
// Edge-counter checks are compiled in when PAD_INPUT_FILTER_EDGE_CNT_EN is defined.
module tb_pad_input_filter;

    localparam int SYNC = 2;
    localparam int FW   = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en  = 1'b1;
    logic          pad = 1'b0;
    logic [FW-1:0] filt_len = 8'd3;
    logic          level, rise, fall, glitch;

    logic          pad1 = 1'b1;
    logic          level1, rise1, fall1, glitch1;

`ifdef PAD_INPUT_FILTER_EDGE_CNT_EN
    logic          cnt_clr = 1'b0;
    logic [15:0]   ecnt, ecnt1;
    int            m_ecnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pad_input_filter #(.SYNC_STAGES(SYNC), .FILT_W(FW), .RESET_VAL(1'b0)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .en_i       (en),
        .pad_i      (pad),
        .filt_len_i (filt_len),
`ifdef PAD_INPUT_FILTER_EDGE_CNT_EN
        .cnt_clr_i  (cnt_clr),
        .edge_cnt_o (ecnt),
`endif
        .level_o    (level),
        .rise_o     (rise),
        .fall_o     (fall),
        .glitch_o   (glitch)
    );

    // Pull-up flavour, pad held high, used only for the reset-value scenario.
    pad_input_filter #(.SYNC_STAGES(SYNC), .FILT_W(FW), .RESET_VAL(1'b1)) dut_pu (
        .clk_i      (clk),
        .rst_i      (rst),
        .en_i       (1'b1),
        .pad_i      (pad1),
        .filt_len_i (8'd3),
`ifdef PAD_INPUT_FILTER_EDGE_CNT_EN
        .cnt_clr_i  (1'b0),
        .edge_cnt_o (ecnt1),
`endif
        .level_o    (level1),
        .rise_o     (rise1),
        .fall_o     (fall1),
        .glitch_o   (glitch1)
    );

    // Reference model: pad delay line plus a count of consecutive differing samples.
    bit pipe[$];
    bit m_level, m_rise, m_fall, m_glitch;
    int m_run, m_lq;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_update();
        bit s;
        if (rst) begin
            pipe.delete();
            for (int i = 0; i < SYNC; i++) pipe.push_back(1'b0);
            m_level = 1'b0; m_run = 0; m_lq = 0;
            m_rise = 1'b0; m_fall = 1'b0; m_glitch = 1'b0;
`ifdef PAD_INPUT_FILTER_EDGE_CNT_EN
            m_ecnt = 0;
`endif
        end else begin
`ifdef PAD_INPUT_FILTER_EDGE_CNT_EN
            if (cnt_clr) m_ecnt = 0;
            else if (m_rise || m_fall) m_ecnt = (m_ecnt + 1) % 65536;
`endif
            s = pipe.pop_front();
            pipe.push_back(pad);
            m_rise = 1'b0; m_fall = 1'b0; m_glitch = 1'b0;
            if (!en) begin
                m_run = 0;
            end else if (s != m_level) begin
                if (m_run == 0) m_lq = int'(filt_len);
                m_run++;
                if (m_run == m_lq + 1) begin
                    m_level = s;
                    m_rise  = s;
                    m_fall  = !s;
                    m_run   = 0;
                end
            end else begin
                if (m_run > 0) m_glitch = 1'b1;
                m_run = 0;
            end
        end
    endtask

    // One clock: update the model with the inputs the DUT samples, then compare on the falling edge.
    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        chk("level",  {31'd0, level},  {31'd0, m_level});
        chk("rise",   {31'd0, rise},   {31'd0, m_rise});
        chk("fall",   {31'd0, fall},   {31'd0, m_fall});
        chk("glitch", {31'd0, glitch}, {31'd0, m_glitch});
`ifdef PAD_INPUT_FILTER_EDGE_CNT_EN
        chk("edge_cnt", {16'd0, ecnt}, m_ecnt);
`endif
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Step until rise_o is seen; returns the step index (1-based) or 0 if the budget runs out.
    task automatic wait_rise(input int budget, output int at);
        at = 0;
        for (int i = 1; i <= budget; i++) begin
            step();
            if (rise === 1'b1 && at == 0) at = i;
            if (at != 0) break;
        end
    endtask

    initial begin
        int at, rises, falls, glitches, r_at, f_at, run_left;

        for (int i = 0; i < SYNC; i++) pipe.push_back(1'b0);

        // Reset, then check both flavours settle without pulses.
        @(negedge clk);
        rst = 1'b1;
        steps(3);
        chk("rst_level0", {31'd0, level}, 32'd0);
        chk("rst_level1", {31'd0, level1}, 32'd1);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("pu_level",  {31'd0, level1}, 32'd1);
            chk("pu_pulses", {29'd0, rise1, fall1, glitch1}, 32'd0);
        end

        // L=3: rising edge accepted SYNC+4 cycles after the pad change.
        filt_len = 8'd3;
        pad = 1'b1;
        wait_rise(50, at);
        chk("l3_rise_latency", at, SYNC + 4);
        chk("l3_level", {31'd0, level}, 32'd1);
        pad = 1'b0;
        steps(12);

        // L=3: two-cycle high pulse is rejected as a glitch.
        rises = 0; glitches = 0;
        pad = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step(); rises += int'(rise); glitches += int'(glitch);
        end
        pad = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step(); rises += int'(rise); glitches += int'(glitch);
        end
        chk("l3_glitch_rises", rises, 0);
        chk("l3_glitch_count", glitches, 1);
        chk("l3_glitch_level", {31'd0, level}, 32'd0);

        // L=0: single-cycle pad pulse passes, rise then fall one cycle apart.
        filt_len = 8'd0;
        r_at = 0; f_at = 0;
        pad = 1'b1;
        step();
        pad = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (rise === 1'b1) r_at = i;
            if (fall === 1'b1) f_at = i;
        end
        chk("l0_rise_seen", {31'd0, r_at != 0}, 32'd1);
        chk("l0_fall_gap", f_at - r_at, 1);

        // L=5: enable dropped mid-qualification; a fresh run starts when it returns.
        filt_len = 8'd5;
        pad = 1'b1;
        steps(4);
        en = 1'b0;
        rises = 0; falls = 0; glitches = 0;
        for (int i = 0; i < 10; i++) begin
            step(); rises += int'(rise); falls += int'(fall); glitches += int'(glitch);
        end
        chk("en_off_pulses", rises + falls + glitches, 0);
        en = 1'b1;
        wait_rise(30, at);
        chk("en_on_rise_latency", at, 6);
        pad = 1'b0;
        steps(12);

        // L=4: reset in the middle of a qualification.
        filt_len = 8'd4;
        pad = 1'b1;
        steps(4);
        rst = 1'b1;
        pad = 1'b0;
        step();
        chk("rst_mid_level", {31'd0, level}, 32'd0);
        rst = 1'b0;
        rises = 0; glitches = 0;
        for (int i = 0; i < 10; i++) begin
            step(); rises += int'(rise); glitches += int'(glitch);
        end
        chk("rst_mid_pulses", rises + glitches, 0);

        // Maximum length: accept after 256 samples with no counter wrap.
        filt_len = 8'd255;
        pad = 1'b1;
        wait_rise(400, at);
        chk("lmax_rise_latency", at, SYNC + 256);
        filt_len = 8'd0;
        pad = 1'b0;
        steps(6);

`ifdef PAD_INPUT_FILTER_EDGE_CNT_EN
        // Edge counter: three pad pulses give six edges, then clear.
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int t = 0; t < 3; t++) begin
            pad = 1'b1; step();
            pad = 1'b0; steps(2);
        end
        steps(5);
        chk("ecnt_six", {16'd0, ecnt}, 32'd6);
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        chk("ecnt_clr", {16'd0, ecnt}, 32'd0);
`endif

        // Random traffic: pad runs of random length, occasional length/enable/reset changes.
        run_left = 0;
        for (int i = 0; i < 3000; i++) begin
            if (run_left == 0) begin
                pad = ~pad;
                run_left = int'($urandom_range(1, 9));
            end
            run_left--;
            if ($urandom_range(0, 19) == 0) filt_len = FW'($urandom_range(0, 6));
            en  = ($urandom_range(0, 19) != 0);
            rst = ($urandom_range(0, 199) == 0);
`ifdef PAD_INPUT_FILTER_EDGE_CNT_EN
            cnt_clr = ($urandom_range(0, 49) == 0);
`endif
            step();
        end
        rst = 1'b0;
        en  = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
